// File: rtl/ped_pkg.sv
// Shared state encoding and default phase timings for the pedestrian crossing controller.
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    CLEAR = 2'd2,
    FAULT = 2'd3
  } ped_state_e;

  localparam int unsigned DEF_WALK_CYCLES  = 8;
  localparam int unsigned DEF_CLEAR_CYCLES = 6;
  localparam int unsigned DEF_FLASH_HALF   = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ped_down_counter.sv
// Loadable down counter with zero flag; load wins over decrement, decrement stops at zero.
// Count is registered; zero_o reflects the current registered count.
module ped_down_counter
  import ped_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: grants WALK only inside a vehicle red phase, then a flashing clearance.
// All outputs registered; an input change shows at the outputs one clock later.
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned WALK_CYCLES  = DEF_WALK_CYCLES,
  parameter int unsigned CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int unsigned FLASH_HALF   = DEF_FLASH_HALF,
  localparam int unsigned CW = $clog2(max_u(WALK_CYCLES, CLEAR_CYCLES) + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          red,
  input  logic          yellow,
  input  logic          green,
  input  logic          ped_btn,
  output logic          walk,
  output logic          dont_walk,
  output logic [CW-1:0] countdown,
  output logic          req_pending,
  output logic          abort,
  output logic          fault
);

  localparam int unsigned FW = $clog2(FLASH_HALF + 1);

  ped_state_e    state_q, state_d;
  logic          red_q, btn_q;
  logic          req_q, req_d;
  logic          flash_q, flash_d;
  logic          abort_d;
  logic          walk_q, walk_d;
  logic          dont_walk_q, dont_walk_d;
  logic [CW-1:0] countdown_q, countdown_d;
  logic          abort_q, fault_q, fault_d;

  logic          ph_load, ph_dec, ph_zero;
  logic [CW-1:0] ph_val, ph_cnt;
  logic          fl_load, fl_dec, fl_zero;
  logic [FW-1:0] fl_val, fl_cnt_unused;

  logic [1:0]    lamp_sum;
  logic          illegal, btn_rise, red_rise;

  assign lamp_sum = {1'b0, red} + {1'b0, yellow} + {1'b0, green};
  assign illegal  = (lamp_sum != 2'd1);
  assign btn_rise = ped_btn & ~btn_q;
  assign red_rise = red & ~red_q;

  ped_down_counter #(.W(CW)) u_phase_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .dec_i      (ph_dec),
    .cnt_o      (ph_cnt),
    .zero_o     (ph_zero)
  );

  ped_down_counter #(.W(FW)) u_flash_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (fl_load),
    .load_val_i (fl_val),
    .dec_i      (fl_dec),
    .cnt_o      (fl_cnt_unused),
    .zero_o     (fl_zero)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    flash_d = flash_q;
    abort_d = 1'b0;
    ph_load = 1'b0;
    ph_dec  = 1'b0;
    ph_val  = '0;
    fl_load = 1'b0;
    fl_dec  = 1'b0;
    fl_val  = FW'(FLASH_HALF - 1);

    unique case (state_q)
      IDLE: begin
        if (btn_rise) req_d = 1'b1;
        if (illegal) begin
          state_d = FAULT;
        end else if (red_rise && (req_q || btn_rise)) begin
          state_d = WALK;
          ph_load = 1'b1;
          ph_val  = CW'(WALK_CYCLES - 1);
        end
      end
      WALK: begin
        if (illegal) begin
          state_d = FAULT;
        end else if (!red) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (ph_zero) begin
          state_d = CLEAR;
          ph_load = 1'b1;
          ph_val  = CW'(CLEAR_CYCLES - 1);
          flash_d = 1'b1;
          fl_load = 1'b1;
        end else begin
          ph_dec = 1'b1;
        end
      end
      CLEAR: begin
        if (illegal) begin
          state_d = FAULT;
        end else if (!red) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (ph_zero) begin
          state_d = IDLE;
        end else begin
          ph_dec = 1'b1;
          if (fl_zero) begin
            flash_d = ~flash_q;
            fl_load = 1'b1;
          end else begin
            fl_dec = 1'b1;
          end
        end
      end
      FAULT: begin
        if (btn_rise) req_d = 1'b1;
        if (!illegal) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Entering WALK or FAULT consumes the request, overriding a same-cycle press.
    if ((state_d == WALK && state_q != WALK) || (state_d == FAULT && state_q != FAULT)) begin
      req_d = 1'b0;
    end

    walk_d      = (state_d == WALK);
    fault_d     = (state_d == FAULT);
    dont_walk_d = (state_d == CLEAR) ? flash_d : (state_d != WALK);
    countdown_d = '0;
    if (state_d == CLEAR) begin
      countdown_d = ph_load ? ph_val : (ph_cnt - CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      red_q       <= 1'b0;
      btn_q       <= 1'b0;
      req_q       <= 1'b0;
      flash_q     <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
      countdown_q <= '0;
      abort_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      red_q       <= red;
      btn_q       <= ped_btn;
      req_q       <= req_d;
      flash_q     <= flash_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      countdown_q <= countdown_d;
      abort_q     <= abort_d;
      fault_q     <= fault_d;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign countdown   = countdown_q;
  assign req_pending = req_q;
  assign abort       = abort_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed vector bench for ped_crossing_ctrl with default timing (WALK 8, CLEAR 6, flash half 2).
module tb_ped_crossing_ctrl;

  logic       clk = 1'b0;
  logic       rst, red, yellow, green, ped_btn;
  logic       walk, dont_walk, req_pending, abort, fault;
  logic [3:0] countdown;

  int checks = 0;
  int errors = 0;

  ped_crossing_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .ped_btn     (ped_btn),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .countdown   (countdown),
    .req_pending (req_pending),
    .abort       (abort),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       i_rst, i_red, i_yel, i_grn, i_btn;
    logic       e_walk, e_dw;
    logic [3:0] e_cd;
    logic       e_req, e_ab, e_flt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic rd, input logic y, input logic g,
                              input logic b, input logic w, input logic dw, input logic [3:0] cd,
                              input logic rq, input logic ab, input logic f);
    vec_t v;
    v.i_rst = r;  v.i_red = rd; v.i_yel = y; v.i_grn = g; v.i_btn = b;
    v.e_walk = w; v.e_dw = dw;  v.e_cd = cd; v.e_req = rq; v.e_ab = ab; v.e_flt = f;
    return v;
  endfunction

  // Drive one cycle of inputs, then compare the outputs registered at the next edge.
  task automatic step(input vec_t v, input string name);
    logic [8:0] got, exp;
    rst = v.i_rst; red = v.i_red; yellow = v.i_yel; green = v.i_grn; ped_btn = v.i_btn;
    @(posedge clk);
    #1;
    got = {walk, dont_walk, countdown, req_pending, abort, fault};
    exp = {v.e_walk, v.e_dw, v.e_cd, v.e_req, v.e_ab, v.e_flt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got walk=%0b dw=%0b cd=%0d req=%0b abort=%0b fault=%0b, expected walk=%0b dw=%0b cd=%0d req=%0b abort=%0b fault=%0b",
               name, walk, dont_walk, countdown, req_pending, abort, fault,
               v.e_walk, v.e_dw, v.e_cd, v.e_req, v.e_ab, v.e_flt);
    end
  endtask

  initial begin
    logic [5:0] clr_dw;
    rst = 1'b1; red = 1'b0; yellow = 1'b0; green = 1'b0; ped_btn = 1'b0;
    clr_dw = 6'b110011;

    // Reset, button during green, red rise grants WALK, full clearance, then a mid-red press.
    tbl.push_back(mk(1, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1,  0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1,  0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  0, 1, 0, 1, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 1, 0, 0, 0,  0, clr_dw[5-k], 4'(5 - k), 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,  0, 1, 0, 1, 0, 0));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(0, 1, 0, 0, 0,  0, 1, 0, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("normal[%0d]", i));

    // Pending request from mid-red waits for the next red rise; red lost in WALK cycle 3 aborts.
    step(mk(0, 0, 0, 1, 0,  0, 1, 0, 1, 0, 0), "deferred_green");
    step(mk(0, 0, 1, 0, 0,  0, 1, 0, 1, 0, 0), "deferred_yellow");
    for (int k = 0; k < 3; k++) step(mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0), $sformatf("abort_walk%0d", k));
    step(mk(0, 0, 0, 1, 0,  0, 1, 0, 0, 1, 0), "abort_pulse");
    step(mk(0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0), "abort_one_cycle");

    // Red phase with no request never walks.
    step(mk(0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0), "noreq_yellow");
    for (int k = 0; k < 10; k++) step(mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0), $sformatf("noreq_red%0d", k));

    // Illegal red+green in IDLE drops the request; recovery needs a new request and red rise.
    step(mk(0, 0, 0, 1, 1,  0, 1, 0, 1, 0, 0), "fault_req");
    step(mk(0, 1, 0, 1, 0,  0, 1, 0, 0, 0, 1), "fault_enter");
    step(mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0), "fault_exit");
    for (int k = 0; k < 5; k++) step(mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0), $sformatf("fault_nowalk%0d", k));

    // Button rise coincident with red rise, then reset in the middle of CLEAR.
    step(mk(0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0), "simul_green");
    step(mk(0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0), "simul_grant");
    for (int k = 0; k < 7; k++) step(mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0), $sformatf("simul_walk%0d", k));
    step(mk(0, 1, 0, 0, 0,  0, 1, 5, 0, 0, 0), "simul_clear5");
    step(mk(0, 1, 0, 0, 0,  0, 1, 4, 0, 0, 0), "simul_clear4");
    step(mk(1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0), "rst_mid_clear");
    step(mk(0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0), "post_rst_idle");

    // Illegal lamps during WALK go straight to FAULT without an abort pulse.
    step(mk(0, 0, 0, 1, 1,  0, 1, 0, 1, 0, 0), "wfault_req");
    step(mk(0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0), "wfault_walk");
    step(mk(0, 1, 1, 0, 0,  0, 1, 0, 0, 0, 1), "wfault_enter");
    step(mk(0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1), "wfault_dark");
    step(mk(0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0), "wfault_exit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
